// File: rtl/sensor_wr_arbiter_pkg.sv
// Shared definitions for the sensor write arbiter: source indices, frame RAM
// address map, burst lengths, FSM states and sample byte packing.
package sensor_wr_arbiter_pkg;

    localparam logic [1:0] SRC_MPU   = 2'd0;
    localparam logic [1:0] SRC_FLOW  = 2'd1;
    localparam logic [1:0] SRC_PRESS = 2'd2;
    localparam logic [1:0] SRC_ULTRA = 2'd3;

    localparam logic [4:0] MPU_BASE   = 5'd0;
    localparam logic [4:0] SEQ_ADDR   = 5'd20;
    localparam logic [4:0] OVF_ADDR   = 5'd21;
    localparam logic [4:0] FLOW_ADDR  = 5'd24;
    localparam logic [4:0] PRESS_ADDR = 5'd28;
    localparam logic [4:0] ULTRA_ADDR = 5'd30;

    localparam logic [4:0] MPU_LEN  = 5'd20;
    localparam logic [4:0] SENS_LEN = 5'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        HDR   = 2'd2,
        LOCK  = 2'd3
    } state_t;

    function automatic logic [4:0] base_addr(input logic [1:0] src);
        case (src)
            SRC_MPU:   return MPU_BASE;
            SRC_FLOW:  return FLOW_ADDR;
            SRC_PRESS: return PRESS_ADDR;
            default:   return ULTRA_ADDR;
        endcase
    endfunction

    function automatic logic [4:0] burst_len(input logic [1:0] src);
        return (src == SRC_MPU) ? MPU_LEN : SENS_LEN;
    endfunction

    // Bytes are packed in write order, so burst byte k always sits at [8k+7:8k].
    function automatic logic [159:0] pack_sample(input logic [1:0]   src,
                                                 input logic [159:0] mpu,
                                                 input logic [55:0]  flow,
                                                 input logic [31:0]  press,
                                                 input logic [15:0]  ultra);
        logic [159:0] s;
        s = '0;
        case (src)
            SRC_MPU:   s = mpu;
            SRC_FLOW:  s[15:0] = {flow[23:16], flow[15:8]};
            SRC_PRESS: s[15:0] = {press[7:0], press[15:8]};
            default:   s[15:0] = {ultra[7:0], ultra[15:8]};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sensor_wr_arbiter_if.sv
// Sensor/radio/frame-RAM signal bundle; slave is the arbiter side, master the
// surrounding sensor and radio logic.
interface sensor_wr_arbiter_if;
    logic [3:0]   rdy_in;
    logic [159:0] mpu_dat;
    logic [55:0]  flow_dat;
    logic [31:0]  press_dat;
    logic [15:0]  ultra_dat;
    logic         tx_req;
    logic         tx_done;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_dat;
    logic         tx_gnt;
    logic [3:0]   ovf_flg;
    logic         busy;

    modport master (
        output rdy_in, mpu_dat, flow_dat, press_dat, ultra_dat, tx_req, tx_done,
        input  wr_en, wr_addr, wr_dat, tx_gnt, ovf_flg, busy
    );

    modport slave (
        input  rdy_in, mpu_dat, flow_dat, press_dat, ultra_dat, tx_req, tx_done,
        output wr_en, wr_addr, wr_dat, tx_gnt, ovf_flg, busy
    );
endinterface

// File: rtl/sensor_wr_arbiter_rr_arb4.sv
// Four-way round-robin pick: first pending source at or after ptr, modulo 4.
module rr_arb4
    import sensor_wr_arbiter_pkg::*;
(
    input  logic [3:0] pend,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!valid && pend[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/sensor_wr_arbiter.sv
// Collects sensor samples into a 32x8 frame RAM by round-robin bursts and hands
// the frame to the radio driver under a tx_req/tx_gnt/tx_done lock.
module sensor_wr_arbiter
    import sensor_wr_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              Clr_Rdy_flg,
    sensor_wr_arbiter_if.slave bus
);

    state_t       state, state_nxt;
    logic [3:0]   rdy_d, armed, rdy_rise, pend, pend_clr, ovf;
    logic [1:0]   ptr, src, grant;
    logic         gvalid, take, wr_c, ovf_clr, seq_inc;
    logic [4:0]   cnt, cnt_nxt, last_addr, addr_c;
    logic [7:0]   frame_seq, last_dat, dat_c;
    logic [159:0] snap;

    rr_arb4 u_arb (
        .pend  (pend),
        .ptr   (ptr),
        .grant (grant),
        .valid (gvalid)
    );

    // armed masks sources that were already high when reset released
    always_comb rdy_rise = bus.rdy_in & ~rdy_d & armed;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_clr  = '0;
        take      = 1'b0;
        wr_c      = 1'b0;
        addr_c    = last_addr;
        dat_c     = last_dat;
        ovf_clr   = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tx_req) begin
                    state_nxt = HDR;
                    cnt_nxt   = '0;
                end else if (gvalid) begin
                    state_nxt      = BURST;
                    cnt_nxt        = '0;
                    take           = 1'b1;
                    pend_clr[grant] = 1'b1;
                end
            end
            BURST: begin
                wr_c   = 1'b1;
                addr_c = base_addr(src) + cnt;
                dat_c  = snap[{cnt, 3'b000} +: 8];
                if (cnt == burst_len(src) - 5'd1) state_nxt = IDLE;
                else                              cnt_nxt   = cnt + 5'd1;
            end
            HDR: begin
                wr_c = 1'b1;
                if (cnt == 5'd0) begin
                    addr_c  = SEQ_ADDR;
                    dat_c   = frame_seq;
                    cnt_nxt = 5'd1;
                end else begin
                    addr_c    = OVF_ADDR;
                    dat_c     = {4'b0000, ovf};
                    ovf_clr   = 1'b1;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (bus.tx_done) begin
                    state_nxt = IDLE;
                    seq_inc   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Clr_Rdy_flg) begin
        if (Clr_Rdy_flg) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_d     <= '0;
            armed     <= '0;
            pend      <= '0;
            ovf       <= '0;
            ptr       <= '0;
            src       <= '0;
            snap      <= '0;
            frame_seq <= '0;
            last_addr <= '0;
            last_dat  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rdy_d     <= bus.rdy_in;
            armed     <= armed | ~bus.rdy_in;
            // a new edge wins over the grant clear; a fresh overrun wins over the header clear
            pend      <= (pend & ~pend_clr) | rdy_rise;
            ovf       <= (ovf & ~{4{ovf_clr}}) | (rdy_rise & pend);
            last_addr <= addr_c;
            last_dat  <= dat_c;
            if (take) begin
                src  <= grant;
                ptr  <= grant + 2'd1;
                snap <= pack_sample(grant, bus.mpu_dat, bus.flow_dat,
                                    bus.press_dat, bus.ultra_dat);
            end
            if (seq_inc) frame_seq <= frame_seq + 8'd1;
        end
    end

    assign bus.wr_en   = wr_c;
    assign bus.wr_addr = addr_c;
    assign bus.wr_dat  = dat_c;
    assign bus.tx_gnt  = (state == LOCK);
    assign bus.ovf_flg = ovf;
    assign bus.busy    = (state != IDLE);

endmodule

// File: doc/sensor_wr_arbiter.md
SENSOR_WR_ARBITER -- requirements
Module: sensor_wr_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port Clr_Rdy_flg  input  1  reset Clr_Rdy_flg, asynchronous, active-high.
REQ-003 SHALL have port rdy_in  input  4  per-source ready, CLK-synchronous; bit0 MPU, 1 FLOW, 2 PRESS, 3 ULTRA.
REQ-004 SHALL have port mpu_dat  input  160  MPU sample, 20 bytes.
REQ-005 SHALL have port flow_dat  input  56  optical-flow sample.
REQ-006 SHALL have port press_dat  input  32  pressure sample.
REQ-007 SHALL have port ultra_dat  input  16  ultrasonic sample.
REQ-008 SHALL have port tx_req  input  1  level; radio driver requests frame lock.
REQ-009 SHALL have port tx_done  input  1  one-cycle pulse; radio finished reading frame.
REQ-010 SHALL have ports wr_en/wr_addr/wr_dat  output  1/5/8  write port of 32x8 frame RAM.
REQ-011 SHALL have port tx_gnt  output  1  frame locked, RAM stable for reading.
REQ-012 SHALL have port ovf_flg  output  4  sticky per-source overrun.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL detect rdy_in rising edges against a one-cycle-delayed copy and set the matching pend bit.
REQ-015 SHALL set ovf_flg[i] when a rising edge arrives while pend[i] is already set.
REQ-016 SHALL, when a new edge and the grant-clear of pend[i] coincide, leave pend[i] set.
REQ-017 SHALL implement states IDLE, BURST, HDR, LOCK.
REQ-018 IDLE SHALL go to HDR if tx_req=1 (priority over pend), else to BURST if any pend bit set, else stay.
REQ-019 SHALL select the source round-robin: first pend bit at or after ptr, modulo 4; ptr becomes granted+1 mod 4.
REQ-020 SHALL, on IDLE->BURST, snapshot the granted source data and clear its pend bit in the same edge.
REQ-021 BURST SHALL assert wr_en one byte per cycle from the snapshot, never split by tx_req, then return to IDLE.
REQ-022 Address map SHALL be: MPU byte k (bits 8k+7:8k) at addr k, k=0..19; FLOW [15:8]->24, [23:16]->25; PRESS [15:8]->28, [7:0]->29; ULTRA [15:8]->30, [7:0]->31.
REQ-023 HDR SHALL write addr 20 = frame_seq, then addr 21 = {4'b0, ovf_flg}, clear ovf_flg on the second write (new overruns that cycle win), then enter LOCK.
REQ-024 LOCK SHALL hold tx_gnt=1 and wr_en=0; pend bits keep accumulating.
REQ-025 LOCK SHALL, on tx_done, drop tx_gnt, increment 8-bit frame_seq (wraps 255->0), and return to IDLE.
REQ-026 tx_done outside LOCK SHALL be ignored.
REQ-027 First wr_en SHALL occur 2 cycles after the rising edge of an uncontended rdy_in; burst lengths: MPU 20, others 2.
REQ-028 wr_addr/wr_dat SHALL be held at last values when wr_en=0.

Reset
REQ-029 While Clr_Rdy_flg=1, all outputs, pend, ptr, frame_seq, delayed rdy copy and state SHALL be 0/IDLE.
REQ-030 Reset mid-BURST or mid-LOCK SHALL abandon the frame immediately; no completion write follows.
REQ-031 rdy_in high at reset release SHALL not register an edge until seen low then high.

Structure
REQ-032 A shared package SHALL hold source indices, address-map constants (MPU_BASE 0, SEQ_ADDR 20, OVF_ADDR 21, FLOW_ADDR 24, PRESS_ADDR 28, ULTRA_ADDR 30), burst lengths and state encoding.
REQ-033 Round-robin selection SHALL be one sub-module rr_arb4 (pend[3:0], ptr[1:0] -> grant index, valid).

Verification
REQ-034 MPU rdy edge alone, mpu_dat byte k = k+1 -> 20 writes addr 0..19 data 1..20, first 2 cycles after edge.
REQ-035 All four rdy edges same cycle, ptr=0 -> bursts in order MPU, FLOW, PRESS, ULTRA; ptr ends 0.
REQ-036 tx_req during MPU burst byte 5 -> burst completes to addr 19, then addr20=seq, addr21, tx_gnt=1; tx_done -> seq+1.
REQ-037 Two PRESS edges before grant -> ovf_flg=4'b0100, written as 0x04 at addr 21 then cleared.
REQ-038 256 frames via tx_req/tx_done -> addr 20 sequence 0..255 then 0.
REQ-039 Clr_Rdy_flg pulse mid-LOCK -> tx_gnt=0, wr_en=0, seq=0 same cycle.
